periph_bus_decoder: RTL and testbench

//   Registered, parametrised address decoder and bus sequencer between the CPU data port and
//   NUM_SLV memory-mapped slaves (memory, timer, UART, GPIO, ...). It decodes base/mask regions,

---
 rtl/periph_bus_decoder.sv | 234 +++++++++++++++++++++++
 tb/tb_periph_bus_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : periph_bus_decoder
// Description : Registered base/mask address decoder and bus sequencer between
//               the CPU data port and NUM_SLV memory-mapped slaves. Drives
//               active-low chip selects, waits for the selected slave's ready,
//               aborts hung accesses after TIMEOUT cycles and completes
//               unmapped accesses with a bus error.
//               Optional error log (failed address + saturating count) is
//               built only when the macro DECODER_ERR_LOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_bus_decoder #(
    parameter int                     NUM_SLV  = 4,
    parameter int                     DATA_W   = 32,
    parameter logic [NUM_SLV*32-1:0]  SLV_BASE = {32'hFFFF2000, 32'hFFFF1000,
                                                  32'hFFFF0000, 32'h00000000},
    parameter logic [NUM_SLV*32-1:0]  SLV_MASK = {32'hFFFFF000, 32'hFFFFF000,
                                                  32'hFFFFF000, 32'hFFFFE000},
    parameter int                     TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m_req,
    input  logic                      m_we,
    input  logic [31:0]               m_addr,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_ready,
    output logic                      m_err,
    output logic [NUM_SLV-1:0]        s_cs_n,
    output logic                      s_we,
    input  logic [NUM_SLV-1:0]        s_ready,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic                      err_clr,
    output logic [31:0]               err_addr,
    output logic [7:0]                err_cnt
);

    localparam int         SEL_W        = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [7:0] c_TMO_LAST   = 8'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACCESS  = 2'd1;
    localparam logic [1:0] c_ST_ERROR   = 2'd2;
    localparam logic [1:0] c_ST_RESP    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [7:0]         cnt_q,   cnt_d;
    logic [NUM_SLV-1:0] cs_n_q,  cs_n_d;
    logic               we_q,    we_d;
    logic               ready_q, ready_d;
    logic               err_q,   err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               w_hit;
    logic [SEL_W-1:0]   w_hit_idx;
    logic [NUM_SLV-1:0] w_hit_cs_n;
    logic               w_sel_ready;
    logic [DATA_W-1:0]  w_sel_rdata;

    // Region decode: scan downward so the lowest matching index wins on overlap.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_cs_n = '1;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                w_hit     = 1'b1;
                w_hit_idx = i[SEL_W-1:0];
            end
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_hit && (w_hit_idx == i[SEL_W-1:0])) begin
                w_hit_cs_n[i] = 1'b0;
            end
        end
    end

    // Route the selected slave's ready and read data; all other slaves are ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q == i[SEL_W-1:0]) begin
                w_sel_ready = s_ready[i];
                w_sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Access sequencer: decode in IDLE, wait/timeout in ACCESS, respond in RESP.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        we_d    = we_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            c_ST_IDLE: begin
                if (m_req) begin
                    if (w_hit) begin
                        sel_d   = w_hit_idx;
                        we_d    = m_we;
                        cs_n_d  = w_hit_cs_n;
                        cnt_d   = 8'd0;
                        state_d = c_ST_ACCESS;
                    end else begin
                        state_d = c_ST_ERROR;
                    end
                end
            end
            c_ST_ACCESS: begin
                // Ready is tested first so it wins over a coincident timeout.
                if (w_sel_ready) begin
                    rdata_d = w_sel_rdata;
                    cs_n_d  = '1;
                    we_d    = 1'b0;
                    cnt_d   = 8'd0;
                    ready_d = 1'b1;
                    state_d = c_ST_RESP;
                end else if (cnt_q == c_TMO_LAST) begin
                    rdata_d = '0;
                    cs_n_d  = '1;
                    we_d    = 1'b0;
                    cnt_d   = 8'd0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = c_ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            c_ST_ERROR: begin
                rdata_d = '0;
                ready_d = 1'b1;
                err_d   = 1'b1;
                state_d = c_ST_RESP;
            end
            c_ST_RESP: begin
                // A request seen here is deliberately ignored; it is taken in IDLE.
                state_d = c_ST_IDLE;
            end
            default: begin
                cs_n_d  = '1;
                we_d    = 1'b0;
                cnt_d   = 8'd0;
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous reset; reset aborts any access silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= 8'd0;
            cs_n_q  <= '1;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign m_rdata = rdata_q;
    assign m_ready = ready_q;
    assign m_err   = err_q;
    assign s_cs_n  = cs_n_q;
    assign s_we    = we_q;

`ifdef DECODER_ERR_LOG_EN
    logic [31:0] addr_q,     addr_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;

    // Error log: latch the failing address and count failures on the same edge
    // that raises m_err, so the log is current while m_err is visible.
    always_comb begin
        addr_d     = addr_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if ((state_q == c_ST_IDLE) && m_req) begin
            addr_d = m_addr;
        end
        if (err_clr) begin
            err_addr_d = 32'd0;
            err_cnt_d  = 8'd0;
        end else if (err_d) begin
            err_addr_d = addr_q;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Error log registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= 32'd0;
            err_addr_q <= 32'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign err_addr         = 32'd0;
    assign err_cnt          = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_bus_decoder
// Description : Directed self-checking bench for periph_bus_decoder with
//               default parameters (4 slaves, TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_bus_decoder;

`ifdef DECODER_ERR_LOG_EN
    localparam bit c_LOG = 1'b1;
`else
    localparam bit c_LOG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         m_req;
    logic         m_we;
    logic [31:0]  m_addr;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic         m_err;
    logic [3:0]   s_cs_n;
    logic         s_we;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         err_clr;
    logic [31:0]  err_addr;
    logic [7:0]   err_cnt;

    int checks   = 0;
    int failures = 0;

    periph_bus_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .s_cs_n   (s_cs_n),
        .s_we     (s_we),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .err_clr  (err_clr),
        .err_addr (err_addr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = 32'd0;
        s_ready = 4'b0000;
        s_rdata = '0;
        err_clr = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_cs_n",   {28'd0, s_cs_n}, 32'hF);
        chk("rst_we",     {31'd0, s_we},    32'd0);
        chk("rst_ready",  {31'd0, m_ready}, 32'd0);
        chk("rst_err",    {31'd0, m_err},   32'd0);
        chk("rst_rdata",  m_rdata,          32'd0);
        chk("rst_eaddr",  err_addr,         32'd0);
        chk("rst_ecnt",   {24'd0, err_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Read 0x40 from slave0, ready one cycle after chip select
        s_rdata[31:0] = 32'h1234_5678;
        m_req  = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0040;
        tick();
        chk("rd0_cs_a",   {28'd0, s_cs_n},  32'hE);
        chk("rd0_rdy_a",  {31'd0, m_ready}, 32'd0);
        tick();
        chk("rd0_cs_b",   {28'd0, s_cs_n},  32'hE);
        s_ready = 4'b0001;
        tick();
        chk("rd0_ready",  {31'd0, m_ready}, 32'd1);
        chk("rd0_err",    {31'd0, m_err},   32'd0);
        chk("rd0_rdata",  m_rdata,          32'h1234_5678);
        chk("rd0_cs_off", {28'd0, s_cs_n},  32'hF);
        m_req = 1'b0; s_ready = 4'b0000;
        tick();
        chk("rd0_pulse",  {31'd0, m_ready}, 32'd0);
        chk("rd0_hold",   m_rdata,          32'h1234_5678);

        // Write to UART (slave2) with ready already high
        s_rdata[95:64] = 32'h0BAD_0002;
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'hFFFF_1004; s_ready = 4'b0100;
        tick();
        chk("wr2_cs",     {28'd0, s_cs_n},  32'hB);
        chk("wr2_we",     {31'd0, s_we},    32'd1);
        chk("wr2_rdy_a",  {31'd0, m_ready}, 32'd0);
        tick();
        chk("wr2_ready",  {31'd0, m_ready}, 32'd1);
        chk("wr2_err",    {31'd0, m_err},   32'd0);
        m_req = 1'b0; m_we = 1'b0; s_ready = 4'b0000;
        tick();

        // Unmapped read
        m_req = 1'b1; m_addr = 32'h8000_0000;
        tick();
        chk("um_cs",      {28'd0, s_cs_n},  32'hF);
        chk("um_rdy_a",   {31'd0, m_ready}, 32'd0);
        tick();
        chk("um_ready",   {31'd0, m_ready}, 32'd1);
        chk("um_err",     {31'd0, m_err},   32'd1);
        chk("um_rdata",   m_rdata,          32'd0);
        m_req = 1'b0;
        tick();
        chk("um_eaddr",   err_addr,         c_LOG ? 32'h8000_0000 : 32'd0);
        chk("um_ecnt",    {24'd0, err_cnt}, c_LOG ? 32'd1 : 32'd0);

        // Slave1 ready on the last allowed cycle: ready wins over timeout
        s_rdata[63:32] = 32'hCAFE_F00D;
        m_req = 1'b1; m_addr = 32'hFFFF_0000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 16) begin
                chk("lr_cs16", {28'd0, s_cs_n}, 32'hD);
                s_ready = 4'b0010;
            end
        end
        tick();
        chk("lr_ready",   {31'd0, m_ready}, 32'd1);
        chk("lr_err",     {31'd0, m_err},   32'd0);
        chk("lr_rdata",   m_rdata,          32'hCAFE_F00D);
        m_req = 1'b0; s_ready = 4'b0000;
        tick();

        // Slave1 never ready, other slave ready is ignored -> timeout
        s_ready = 4'b0001;
        m_req = 1'b1; m_addr = 32'hFFFF_0000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("to_cs_low", {28'd0, s_cs_n}, 32'hD);
            chk("to_noready", {31'd0, m_ready}, 32'd0);
        end
        tick();
        chk("to_ready",   {31'd0, m_ready}, 32'd1);
        chk("to_err",     {31'd0, m_err},   32'd1);
        chk("to_rdata",   m_rdata,          32'd0);
        chk("to_cs_off",  {28'd0, s_cs_n},  32'hF);
        m_req = 1'b0; s_ready = 4'b0000;
        tick();
        chk("to_ecnt",    {24'd0, err_cnt}, c_LOG ? 32'd2 : 32'd0);
        chk("to_eaddr",   err_addr,         c_LOG ? 32'hFFFF_0000 : 32'd0);

        // Reset two cycles into an access
        m_req = 1'b1; m_addr = 32'h0000_0040;
        tick();
        tick();
        chk("ra_cs_low",  {28'd0, s_cs_n},  32'hE);
        reset = 1'b1; m_req = 1'b0;
        tick();
        chk("ra_cs",      {28'd0, s_cs_n},  32'hF);
        chk("ra_ready",   {31'd0, m_ready}, 32'd0);
        chk("ra_ecnt",    {24'd0, err_cnt}, 32'd0);
        reset = 1'b0;
        tick();
        chk("ra_ready2",  {31'd0, m_ready}, 32'd0);
        s_rdata[127:96] = 32'h3333_AAAA;
        s_ready = 4'b1000;
        m_req = 1'b1; m_addr = 32'hFFFF_2010;
        tick();
        chk("ra_cs3",     {28'd0, s_cs_n},  32'h7);
        tick();
        chk("ra_ready3",  {31'd0, m_ready}, 32'd1);
        chk("ra_rdata3",  m_rdata,          32'h3333_AAAA);
        m_req = 1'b0; s_ready = 4'b0000;
        tick();

        // Request held through RESP is taken as a new access in the next IDLE
        m_req = 1'b1; m_addr = 32'h9000_0000;
        tick();
        tick();
        chk("hd_ready1",  {31'd0, m_ready}, 32'd1);
        tick();
        chk("hd_idle",    {31'd0, m_ready}, 32'd0);
        tick();
        chk("hd_error",   {31'd0, m_ready}, 32'd0);
        tick();
        chk("hd_ready2",  {31'd0, m_ready}, 32'd1);
        chk("hd_err2",    {31'd0, m_err},   32'd1);
        m_req = 1'b0;
        tick();

        // 300 unmapped accesses saturate the counter, then clear
        for (int n = 0; n < 300; n++) begin
            m_req = 1'b1; m_addr = 32'h8000_0000 + 32'(n * 4);
            tick();
            tick();
            m_req = 1'b0;
            tick();
        end
        chk("sat_ecnt",   {24'd0, err_cnt}, c_LOG ? 32'd255 : 32'd0);
        chk("sat_eaddr",  err_addr,         c_LOG ? 32'h8000_04AC : 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_ecnt",   {24'd0, err_cnt}, 32'd0);
        chk("clr_eaddr",  err_addr,         32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
